// File: rtl/rmii_phy_pkg.sv
// Shared types and constants for the RMII PHY endpoint: FSM state enums,
// RMII line codes and the CRC-32 parameters used for optional FCS checking.
package rmii_phy_pkg;

  typedef enum logic [1:0] {D_IDLE, D_PRE, D_DATA} des_state_t;
  typedef enum logic [2:0] {S_IDLE, S_PRE, S_DATA, S_ABORT, S_IFG} ser_state_t;

  localparam logic [1:0]  PREAMBLE_DIBIT = 2'b01;
  localparam logic [1:0]  SFD_LAST_DIBIT = 2'b11;
  localparam logic [31:0] CRC_POLY       = 32'hEDB88320;
  localparam logic [31:0] CRC_RESIDUE    = 32'hDEBB20E3;

  // Reflected CRC-32 advanced by one byte, LSB first.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc_in,
                                             input logic [7:0]  data);
    logic [31:0] c;
    c = crc_in ^ {24'd0, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/rmii_phy_if.sv
// Byte stream bundle used on both sides of the endpoint. The master side
// carries no tready because the received stream has no backpressure.
interface rmii_phy_if;
  logic [7:0] tdata;
  logic       tvalid;
  logic       tready;
  logic       tlast;
  logic       tuser;

  modport master (output tdata, tvalid, tlast, tuser);
  modport slave  (input tdata, tvalid, tlast, tuser, output tready);
endinterface

// File: rtl/rmii_crc32.sv
// Byte-wide reflected CRC-32 register; used only when RMII_PHY_FCS_CHECK_EN
// is defined.
module rmii_crc32
  import rmii_phy_pkg::*;
(
  input  logic        clock50,
  input  logic        reset,
  input  logic        init,
  input  logic        en,
  input  logic [7:0]  data,
  output logic [31:0] crc
);

  always_ff @(posedge clock50 or posedge reset) begin
    if (reset)     crc <= '1;
    else if (init) crc <= '1;
    else if (en)   crc <= crc32_byte(crc, data);
  end

endmodule

// File: rtl/rmii_phy_endpoint.sv
// PHY-side RMII endpoint: MAC TX dibits -> byte stream, byte stream -> RX dibits.
// Define RMII_PHY_FCS_CHECK_EN to flag received frames whose FCS is wrong.
module rmii_phy_endpoint
  import rmii_phy_pkg::*;
#(
  parameter int PREAMBLE_BYTES = 7,
  parameter int IFG_BYTES      = 12
) (
  input  logic        clock50,
  input  logic        reset,
  input  logic        rmii_tx_en,
  input  logic [1:0]  rmii_txd,
  rmii_phy_if.master  m_axis,
  rmii_phy_if.slave   s_axis,
  output logic        rmii_crs_dv,
  output logic [1:0]  rmii_rxd,
  output logic        rmii_rx_er
);

  localparam int PRE_DIBITS = PREAMBLE_BYTES * 4 + 4;
  localparam int IFG_DIBITS = IFG_BYTES * 4;
  localparam int MAX_CNT    = (PRE_DIBITS > IFG_DIBITS) ? PRE_DIBITS : IFG_DIBITS;
  localparam int CNT_W      = $clog2(MAX_CNT + 1);
  localparam logic [CNT_W-1:0] SFD_IDX  = CNT_W'(PRE_DIBITS - 1);
  localparam logic [CNT_W-1:0] SFD_PREV = CNT_W'(PRE_DIBITS - 2);
  localparam logic [CNT_W-1:0] IFG_IDX  = CNT_W'(IFG_DIBITS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] DIBIT2   = CNT_W'(2);
  localparam logic [CNT_W-1:0] DIBIT3   = CNT_W'(3);

  des_state_t d_state;
  logic [1:0] dibit_cnt;
  logic [7:0] byte_p0, byte_p1, byte_done;
  logic       vld_p1;
  logic [7:0] m_tdata_q;
  logic       m_tvalid_q, m_tlast_q, m_tuser_q;
  logic       frame_bad;

  assign byte_done = {rmii_txd, byte_p0[7:2]};

`ifdef RMII_PHY_FCS_CHECK_EN
  logic [31:0] crc_q;
  logic        crc_init, crc_en;
  assign crc_init = (d_state == D_PRE) && rmii_tx_en && (rmii_txd == SFD_LAST_DIBIT);
  assign crc_en   = (d_state == D_DATA) && rmii_tx_en && (dibit_cnt == 2'd3);
  rmii_crc32 u_crc (
    .clock50 (clock50),
    .reset   (reset),
    .init    (crc_init),
    .en      (crc_en),
    .data    (byte_done),
    .crc     (crc_q)
  );
  assign frame_bad = (crc_q != CRC_RESIDUE);
`else
  assign frame_bad = 1'b0;
`endif

  // Deserializer: byte_p0 assembles dibits, byte_p1 holds the byte awaiting emission
  always_ff @(posedge clock50 or posedge reset) begin
    if (reset) begin
      d_state    <= D_IDLE;
      dibit_cnt  <= 2'd0;
      byte_p0    <= 8'd0;
      byte_p1    <= 8'd0;
      vld_p1     <= 1'b0;
      m_tdata_q  <= 8'd0;
      m_tvalid_q <= 1'b0;
      m_tlast_q  <= 1'b0;
      m_tuser_q  <= 1'b0;
    end else begin
      m_tvalid_q <= 1'b0;
      m_tlast_q  <= 1'b0;
      m_tuser_q  <= 1'b0;
      case (d_state)
        D_IDLE: if (rmii_tx_en && rmii_txd == PREAMBLE_DIBIT) d_state <= D_PRE;
        D_PRE: begin
          if (!rmii_tx_en) begin
            d_state <= D_IDLE;
          end else if (rmii_txd == SFD_LAST_DIBIT) begin
            d_state   <= D_DATA;
            dibit_cnt <= 2'd0;
            vld_p1    <= 1'b0;
          end else if (rmii_txd != PREAMBLE_DIBIT) begin
            d_state <= D_IDLE;
          end
        end
        D_DATA: begin
          if (!rmii_tx_en) begin
            d_state <= D_IDLE;
            vld_p1  <= 1'b0;
            if (vld_p1) begin
              m_tdata_q  <= byte_p1;
              m_tvalid_q <= 1'b1;
              m_tlast_q  <= 1'b1;
              m_tuser_q  <= (dibit_cnt != 2'd0) || frame_bad;
            end
          end else begin
            byte_p0   <= byte_done;
            dibit_cnt <= dibit_cnt + 2'd1;
            if (dibit_cnt == 2'd3) begin
              byte_p1 <= byte_done;
              vld_p1  <= 1'b1;
              if (vld_p1) begin
                m_tdata_q  <= byte_p1;
                m_tvalid_q <= 1'b1;
              end
            end
          end
        end
        default: d_state <= D_IDLE;
      endcase
    end
  end

  assign m_axis.tdata  = m_tdata_q;
  assign m_axis.tvalid = m_tvalid_q;
  assign m_axis.tlast  = m_tlast_q;
  assign m_axis.tuser  = m_tuser_q;

  ser_state_t       s_state;
  logic [CNT_W-1:0] s_cnt;
  logic [5:0]       tx_sr;
  logic             last_taken;
  logic             crs_q, er_q, tready_q;
  logic [1:0]       rxd_q;

  // Serializer: outputs are computed one dibit ahead; tready_q marks the byte slot boundary
  always_ff @(posedge clock50 or posedge reset) begin
    if (reset) begin
      s_state    <= S_IDLE;
      s_cnt      <= '0;
      tx_sr      <= 6'd0;
      last_taken <= 1'b0;
      crs_q      <= 1'b0;
      rxd_q      <= 2'b00;
      er_q       <= 1'b0;
      tready_q   <= 1'b0;
    end else if (tready_q) begin
      tready_q <= 1'b0;
      s_cnt    <= '0;
      if (s_axis.tvalid) begin
        s_state    <= S_DATA;
        rxd_q      <= s_axis.tdata[1:0];
        tx_sr      <= s_axis.tdata[7:2];
        er_q       <= s_axis.tuser;
        last_taken <= s_axis.tlast;
      end else begin
        s_state <= S_ABORT;
        rxd_q   <= 2'b00;
        er_q    <= 1'b1;
      end
    end else begin
      case (s_state)
        S_IDLE: if (s_axis.tvalid) begin
          s_state <= S_PRE;
          s_cnt   <= '0;
          crs_q   <= 1'b1;
          rxd_q   <= PREAMBLE_DIBIT;
          er_q    <= 1'b0;
        end
        S_PRE: begin
          s_cnt    <= s_cnt + CNT_ONE;
          rxd_q    <= (s_cnt == SFD_PREV) ? SFD_LAST_DIBIT : PREAMBLE_DIBIT;
          tready_q <= (s_cnt == SFD_PREV);
        end
        S_DATA, S_ABORT: begin
          if (s_cnt == DIBIT3) begin
            s_state <= S_IFG;
            s_cnt   <= '0;
            crs_q   <= 1'b0;
            rxd_q   <= 2'b00;
            er_q    <= 1'b0;
          end else begin
            s_cnt <= s_cnt + CNT_ONE;
            if (s_state == S_DATA) begin
              rxd_q    <= tx_sr[1:0];
              tx_sr    <= {2'b00, tx_sr[5:2]};
              tready_q <= (s_cnt == DIBIT2) && !last_taken;
            end
          end
        end
        S_IFG: begin
          if (s_cnt == IFG_IDX) s_state <= S_IDLE;
          else                  s_cnt   <= s_cnt + CNT_ONE;
        end
        default: s_state <= S_IDLE;
      endcase
    end
  end

  assign rmii_crs_dv   = crs_q;
  assign rmii_rxd      = rxd_q;
  assign rmii_rx_er    = er_q;
  assign s_axis.tready = tready_q;

endmodule

// File: tb/tb_rmii_phy_endpoint.sv
// Bench for rmii_phy_endpoint: frame-level model of both directions plus
// per-cycle comparison and a few literal checks.
module tb_rmii_phy_endpoint;

  localparam int PRE = 7;
  localparam int IFG = 12;

  typedef struct packed { logic crs; logic [1:0] rxd; logic er; logic rdy; } ser_exp_t;
  typedef struct packed { logic [7:0] d; logic l; logic u; } des_exp_t;

  logic       clock50 = 1'b0;
  logic       reset   = 1'b1;
  logic       rmii_tx_en = 1'b0;
  logic [1:0] rmii_txd   = 2'b00;
  logic       rmii_crs_dv, rmii_rx_er;
  logic [1:0] rmii_rxd;

  rmii_phy_if m_axis ();
  rmii_phy_if s_axis ();

  rmii_phy_endpoint #(.PREAMBLE_BYTES(PRE), .IFG_BYTES(IFG)) dut (
    .clock50     (clock50),
    .reset       (reset),
    .rmii_tx_en  (rmii_tx_en),
    .rmii_txd    (rmii_txd),
    .m_axis      (m_axis),
    .s_axis      (s_axis),
    .rmii_crs_dv (rmii_crs_dv),
    .rmii_rxd    (rmii_rxd),
    .rmii_rx_er  (rmii_rx_er)
  );

  always #5 clock50 = ~clock50;

  int total = 0;
  int bad   = 0;
  logic hold_chk = 1'b1;
  logic stop_drv = 1'b0;
  ser_exp_t ser_q[$];
  des_exp_t des_q[$];
  logic [7:0] tx_bytes[4];
  logic       tx_user[4];
  logic [7:0] rx_bytes[64];
  logic [7:0] last_tdata = 8'd0;
  logic       last_tuser = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] crc_calc(input int n);
    logic [31:0] r;
    logic fb;
    r = 32'hFFFFFFFF;
    for (int i = 0; i < n; i++)
      for (int b = 0; b < 8; b++) begin
        fb = r[0] ^ rx_bytes[i][b];
        r  = r >> 1;
        if (fb) r = r ^ 32'hEDB88320;
      end
    return r;
  endfunction

  // Expected RX line per cycle: one idle cycle, preamble+SFD, data, optional abort, gap.
  task automatic model_ser(input int n, input int supply);
    ser_q.push_back(ser_exp_t'(0));
    for (int i = 0; i < PRE * 4 + 3; i++) ser_q.push_back('{1'b1, 2'b01, 1'b0, 1'b0});
    ser_q.push_back('{1'b1, 2'b11, 1'b0, 1'b1});
    for (int i = 0; i < supply; i++)
      for (int k = 0; k < 4; k++)
        ser_q.push_back('{1'b1, tx_bytes[i][2*k +: 2], tx_user[i], (k == 3 && i != n - 1)});
    if (supply < n)
      for (int k = 0; k < 4; k++) ser_q.push_back('{1'b1, 2'b00, 1'b1, 1'b0});
    for (int i = 0; i < IFG * 4; i++) ser_q.push_back(ser_exp_t'(0));
  endtask

  task automatic model_des(input int n, input int extra);
    logic u;
    u = (extra != 0);
`ifdef RMII_PHY_FCS_CHECK_EN
    u = u | (crc_calc(n) != 32'hDEBB20E3);
`endif
    for (int i = 0; i < n; i++)
      des_q.push_back('{rx_bytes[i], (i == n - 1), (i == n - 1) ? u : 1'b0});
  endtask

  // Single compare process for both directions.
  always @(negedge clock50) begin
    ser_exp_t e;
    des_exp_t d;
    if (!hold_chk) begin
      e = (ser_q.size() > 0) ? ser_q.pop_front() : ser_exp_t'(0);
      chk("ser_line", {27'd0, rmii_crs_dv, rmii_rxd, rmii_rx_er, s_axis.tready}, {27'd0, e});
      if (m_axis.tvalid) begin
        if (des_q.size() == 0) begin
          chk("des_unexpected", {21'd0, m_axis.tlast, m_axis.tuser, m_axis.tdata}, 32'hFFFFFFFF);
        end else begin
          d = des_q.pop_front();
          chk("des_byte", {22'd0, m_axis.tdata, m_axis.tlast, m_axis.tuser}, {22'd0, d});
        end
        last_tdata = m_axis.tdata;
        last_tuser = m_axis.tuser;
      end
    end
  end

  task automatic drive(input logic en, input logic [1:0] d);
    @(posedge clock50);
    #1;
    rmii_tx_en = stop_drv ? 1'b0 : en;
    rmii_txd   = stop_drv ? 2'b00 : d;
  endtask

  task automatic send_mac(input int n, input int extra);
    model_des(n, extra);
    for (int i = 0; i < PRE * 4 + 3; i++) drive(1'b1, 2'b01);
    drive(1'b1, 2'b11);
    for (int i = 0; i < n; i++)
      for (int k = 0; k < 4; k++) drive(1'b1, rx_bytes[i][2*k +: 2]);
    for (int k = 0; k < extra; k++) drive(1'b1, 2'b10);
    drive(1'b0, 2'b00);
    @(posedge clock50);
    @(negedge clock50);
    if (n > 0 && !stop_drv) chk("des_tlast_time", {30'd0, m_axis.tvalid, m_axis.tlast}, 32'd3);
    repeat (3) @(posedge clock50);
  endtask

  task automatic load_byte(input int i, input int n);
    s_axis.tdata = tx_bytes[i];
    s_axis.tuser = tx_user[i];
    s_axis.tlast = (i == n - 1);
  endtask

  task automatic send_axis(input int n, input int supply);
    int idx;
    int guard;
    idx = 0;
    guard = 0;
    @(posedge clock50);
    #1;
    model_ser(n, supply);
    load_byte(0, n);
    s_axis.tvalid = 1'b1;
    while (idx < supply && guard < 1000 && !stop_drv) begin
      @(negedge clock50);
      guard++;
      if (s_axis.tready) begin
        @(posedge clock50);
        #1;
        idx++;
        if (idx < supply) load_byte(idx, n);
        else s_axis.tvalid = 1'b0;
      end
    end
    s_axis.tvalid = 1'b0;
    s_axis.tlast  = 1'b0;
    s_axis.tuser  = 1'b0;
    if (guard >= 1000) chk("ser_drv_timeout", guard, 0);
  endtask

  // Direct observation of one RX burst: length, data dibits 32..39, rx_er cycles.
  task automatic mon_ser(output int hi, output logic [15:0] dat, output int erc);
    int g;
    g = 0; hi = 0; dat = 16'd0; erc = 0;
    while (!rmii_crs_dv && g < 100) begin
      @(negedge clock50);
      g++;
    end
    while (rmii_crs_dv && hi < 200) begin
      if (hi >= PRE * 4 + 4 && hi < PRE * 4 + 12) dat[2*(hi - PRE*4 - 4) +: 2] = rmii_rxd;
      if (rmii_rx_er) erc++;
      hi++;
      @(negedge clock50);
    end
  endtask

  task automatic wait_drain();
    int g;
    g = 0;
    while ((ser_q.size() != 0 || des_q.size() != 0) && g < 3000) begin
      @(negedge clock50);
      g++;
    end
    chk("drain", ser_q.size() + des_q.size(), 0);
    repeat (2) @(posedge clock50);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int hi, erc;
    logic [15:0] dat;
    logic [31:0] fcs;
    s_axis.tdata = 8'd0; s_axis.tvalid = 1'b0; s_axis.tlast = 1'b0; s_axis.tuser = 1'b0;
    repeat (3) @(posedge clock50);
    #1;
    chk("reset_ser", {rmii_crs_dv, rmii_rxd, rmii_rx_er, s_axis.tready}, 0);
    chk("reset_maxis", {m_axis.tvalid, m_axis.tlast, m_axis.tuser, m_axis.tdata}, 0);
    reset = 1'b0;
    hold_chk = 1'b0;
    repeat (2) @(posedge clock50);

    rx_bytes[0] = 8'h01; rx_bytes[1] = 8'h02; rx_bytes[2] = 8'h03;
    send_mac(3, 0);
`ifndef RMII_PHY_FCS_CHECK_EN
    chk("des_clean_tuser", last_tuser, 0);
`endif
    chk("des_clean_last", last_tdata, 8'h03);
    send_mac(3, 2);
    chk("des_partial_tuser", last_tuser, 1);
    send_mac(0, 0);
    drive(1'b1, 2'b01); drive(1'b1, 2'b01); drive(1'b1, 2'b10);
    repeat (6) drive(1'b1, 2'b00);
    drive(1'b0, 2'b00);
    wait_drain();

    tx_bytes[0] = 8'hA5; tx_bytes[1] = 8'h3C; tx_user[0] = 1'b0; tx_user[1] = 1'b0;
    fork
      send_axis(2, 2);
      mon_ser(hi, dat, erc);
    join
    chk("ser_crs_len", hi, 40);
    chk("ser_data_dibits", dat, 16'h3CA5);
    wait_drain();

    tx_user[1] = 1'b1;
    fork
      send_axis(2, 2);
      mon_ser(hi, dat, erc);
    join
    chk("ser_tuser_er_cycles", erc, 4);
    wait_drain();

    tx_user[1] = 1'b0;
    fork
      send_axis(2, 1);
      mon_ser(hi, dat, erc);
    join
    chk("ser_abort_len", hi, 40);
    chk("ser_abort_er", erc, 4);
    wait_drain();

    rx_bytes[0] = 8'hF0; rx_bytes[1] = 8'h0F; rx_bytes[2] = 8'h5A;
    fork
      send_axis(2, 2);
      send_mac(3, 0);
    join
    wait_drain();

`ifdef RMII_PHY_FCS_CHECK_EN
    for (int i = 0; i < 60; i++) rx_bytes[i] = 8'(i * 7 + 1);
    fcs = ~crc_calc(60);
    for (int k = 0; k < 4; k++) rx_bytes[60 + k] = fcs[8*k +: 8];
    send_mac(64, 0);
    chk("fcs_good_tuser", last_tuser, 0);
    rx_bytes[10] = rx_bytes[10] ^ 8'h04;
    send_mac(64, 0);
    chk("fcs_bad_tuser", last_tuser, 1);
    wait_drain();
`endif

    rx_bytes[0] = 8'h11; rx_bytes[1] = 8'h22; rx_bytes[2] = 8'h33;
    fork
      send_axis(2, 2);
      send_mac(3, 0);
      begin
        repeat (36) @(negedge clock50);
        hold_chk = 1'b1;
        stop_drv = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        chk("midreset_ser", {rmii_crs_dv, rmii_rxd, rmii_rx_er, s_axis.tready}, 0);
        chk("midreset_maxis", {m_axis.tvalid, m_axis.tlast, m_axis.tuser, m_axis.tdata}, 0);
        @(posedge clock50);
        #1;
        chk("midreset_ser_edge", {rmii_crs_dv, rmii_rxd, rmii_rx_er, s_axis.tready}, 0);
      end
    join
    ser_q.delete();
    des_q.delete();
    @(posedge clock50);
    #1;
    reset = 1'b0;
    stop_drv = 1'b0;
    hold_chk = 1'b0;
    repeat (5) @(posedge clock50);
    rx_bytes[0] = 8'h44; rx_bytes[1] = 8'h55; rx_bytes[2] = 8'h66;
    send_mac(3, 0);
    chk("post_reset_last", last_tdata, 8'h66);
    wait_drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
